if_stage: RTL and testbench

- Fetch stage directly downstream of pre_if_stage.
- Takes the PC, request-valid and exception info launched by pre-IF, collects the ICache read data for that PC, and forwards a {pc, inst, ex, exctype} bundle to the decode stage.
- Generates fs_allowin back to pre-IF.
- Buffers returned instruction data when decode stalls, and discards stale ICache responses after flush/br_flush.

---
 rtl/if_stage_pkg.sv | 41 ++++
 rtl/if_stage.sv | 137 +++++++++++++
 tb/tb_if_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
//   Shared definitions for the instruction fetch stage: bus widths, the packed
//   layouts of the pre-IF -> IF and IF -> ID buses, exception codes and the
//   reset PC.
// -----------------------------------------------------------------------------
package if_stage_pkg;

  localparam int PS_TO_FS_BUS_WD = 39;
  localparam int FS_TO_DS_BUS_WD = 70;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  // MIPS-style exception codes carried in exctype.
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_MOD  = 5'h01;
  localparam logic [4:0] EXC_TLBL = 5'h02;
  localparam logic [4:0] EXC_TLBS = 5'h03;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] NO_EX    = 5'h1f;

  // Instruction substituted when no ICache request was made for the slot.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // {inst_valid, pc, ex, exctype}
  typedef struct packed {
    logic        inst_valid;
    logic [31:0] pc;
    logic        ex;
    logic [4:0]  exctype;
  } ps_to_fs_t;

  // {pc, inst, ex, exctype}
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [4:0]  exctype;
  } fs_to_ds_t;

endpackage

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Fetch stage between pre-IF and decode. Holds one PC slot, pairs it with
//   the ICache read data, buffers that data while decode stalls, and drops the
//   stale ICache response left behind when a flush kills an in-flight fetch.
//
// Ports
//   clk            clock, all state on posedge
//   reset          synchronous active-high reset
//   ps_to_fs_bus   pre-IF payload {inst_valid, pc, ex, exctype}
//   ps_to_fs_valid pre-IF payload valid
//   fs_allowin     fetch stage can accept a payload this cycle
//   icache_busy    ICache is not returning data this cycle
//   icache_rdata   ICache instruction data, valid when icache_busy=0
//   ds_allowin     decode can accept a bundle
//   fs_to_ds_valid bundle valid to decode
//   fs_to_ds_bus   bundle {pc, inst, ex, exctype}
//   flush          exception / eret / refetch flush
//   br_flush       branch mispredict flush
// -----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus,
  input  logic                       ps_to_fs_valid,
  output logic                       fs_allowin,
  input  logic                       icache_busy,
  input  logic [31:0]                icache_rdata,
  input  logic                       ds_allowin,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic                       flush,
  input  logic                       br_flush
);

  ps_to_fs_t ps_in;
  fs_to_ds_t ds_out;

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        fs_req;
  logic        fs_ex;
  logic [4:0]  fs_exctype;
  logic        buf_valid;
  logic [31:0] inst_buf;
  logic        cancel;

  logic        kill;
  logic        fs_ready_go;
  logic        load;
  logic        buf_capture;
  logic        rsp_outstanding;
  logic [31:0] fs_inst;

  assign ps_in = ps_to_fs_bus;
  assign kill  = flush | br_flush;

  // While cancel is set the next returning beat belongs to a killed fetch,
  // so the current slot must not treat it as its own.
  assign fs_ready_go    = ~fs_req | buf_valid | (~icache_busy & ~cancel);
  assign fs_allowin     = kill | ~fs_valid | (fs_ready_go & ds_allowin);
  assign fs_to_ds_valid = fs_valid & fs_ready_go & ~kill;

  assign load = fs_allowin & ps_to_fs_valid & ~kill;

  // ICache data is only present for one cycle; hold it if decode cannot take it.
  assign buf_capture = fs_valid & fs_req & ~buf_valid & ~cancel & ~icache_busy
                     & ~ds_allowin & ~kill;

  // A request has been issued for this slot but its data has not come back.
  assign rsp_outstanding = fs_valid & fs_req & ~buf_valid & icache_busy;

  // NOTE: every output of a combinational block gets a default assignment
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fs_inst = NOP_INST;
    if (buf_valid) begin
      fs_inst = inst_buf;
    end else if (fs_req) begin
      fs_inst = icache_rdata;
    end
  end

  assign ds_out.pc      = fs_pc;
  assign ds_out.inst    = fs_inst;
  assign ds_out.ex      = fs_ex;
  assign ds_out.exctype = fs_exctype;
  assign fs_to_ds_bus   = ds_out;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid   <= 1'b0;
      fs_pc      <= 32'h0;
      fs_req     <= 1'b0;
      fs_ex      <= 1'b0;
      fs_exctype <= 5'h0;
      buf_valid  <= 1'b0;
      inst_buf   <= 32'h0;
      cancel     <= 1'b0;
    end else begin
      // Slot occupancy: kill wins over everything, then the normal handoff.
      if (kill) begin
        fs_valid  <= 1'b0;
        buf_valid <= 1'b0;
      end else if (fs_allowin) begin
        fs_valid  <= ps_to_fs_valid;
        buf_valid <= 1'b0;
      end else if (buf_capture) begin
        buf_valid <= 1'b1;
      end

      if (load) begin
        fs_pc      <= ps_in.pc;
        fs_req     <= ps_in.inst_valid;
        fs_ex      <= ps_in.ex;
        fs_exctype <= ps_in.exctype;
      end

      if (buf_capture) begin
        inst_buf <= icache_rdata;
      end

      // Remember that one returning beat must be swallowed. A kill that
      // arrives while already cancelling keeps the flag up.
      if (kill && (cancel || rsp_outstanding)) begin
        cancel <= 1'b1;
      end else if (cancel && !icache_busy) begin
        cancel <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
//   Self-checking bench for if_stage. Expected decode bundles are queued when
//   a payload is offered to the fetch stage and popped by a monitor whenever
//   decode accepts a bundle. Directed checks cover stall, miss, flush and
//   exception handling.
// -----------------------------------------------------------------------------
module tb_if_stage;
  import if_stage_pkg::*;

  logic                       clk;
  logic                       reset;
  logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus;
  logic                       ps_to_fs_valid;
  logic                       fs_allowin;
  logic                       icache_busy;
  logic [31:0]                icache_rdata;
  logic                       ds_allowin;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       flush;
  logic                       br_flush;

  int n_checks = 0;
  int n_fails  = 0;

  logic [FS_TO_DS_BUS_WD-1:0] sb[$];

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ps_to_fs_bus   (ps_to_fs_bus),
    .ps_to_fs_valid (ps_to_fs_valid),
    .fs_allowin     (fs_allowin),
    .icache_busy    (icache_busy),
    .icache_rdata   (icache_rdata),
    .ds_allowin     (ds_allowin),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .flush          (flush),
    .br_flush       (br_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PS_TO_FS_BUS_WD-1:0] mk_ps(input logic iv, input logic [31:0] pc,
                                                       input logic ex, input logic [4:0] exc);
    return {iv, pc, ex, exc};
  endfunction

  function automatic logic [FS_TO_DS_BUS_WD-1:0] mk_ds(input logic [31:0] pc, input logic [31:0] inst,
                                                       input logic ex, input logic [4:0] exc);
    return {pc, inst, ex, exc};
  endfunction

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer a payload to the fetch stage for the current cycle.
  task automatic offer(input logic iv, input logic [31:0] pc, input logic ex, input logic [4:0] exc);
    ps_to_fs_valid = 1'b1;
    ps_to_fs_bus   = mk_ps(iv, pc, ex, exc);
  endtask

  task automatic idle_ps();
    ps_to_fs_valid = 1'b0;
    ps_to_fs_bus   = '0;
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      cyc();
      budget--;
    end
    if (budget == 0) check({tag, "_drain_timeout"}, 70'(sb.size()), 70'(0));
  endtask

  // Decode-side monitor: every accepted bundle must match the oldest expected.
  always @(negedge clk) begin
    if (!reset && fs_to_ds_valid && ds_allowin) begin
      if (sb.size() == 0) begin
        check("spurious_bundle", 70'(fs_to_ds_valid), 70'(0));
      end else begin
        check("bundle", fs_to_ds_bus, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    ps_to_fs_valid = 1'b0;
    ps_to_fs_bus   = '0;
    icache_busy    = 1'b1;
    icache_rdata   = 32'h0;
    ds_allowin     = 1'b1;
    flush          = 1'b0;
    br_flush       = 1'b0;

    // ---------------- reset ----------------
    cyc();
    cyc();
    @(negedge clk);
    check("rst_allowin", 70'(fs_allowin), 70'(1));
    check("rst_valid",   70'(fs_to_ds_valid), 70'(0));
    check("rst_bus",     70'(fs_to_ds_bus), 70'(0));
    cyc();
    reset = 1'b0;

    // ---------------- streaming ----------------
    offer(1'b1, RESET_PC, 1'b0, NO_EX);
    sb.push_back(mk_ds(RESET_PC, 32'h2408_0001, 1'b0, NO_EX));
    cyc();
    offer(1'b1, RESET_PC + 32'd4, 1'b0, NO_EX);
    sb.push_back(mk_ds(RESET_PC + 32'd4, 32'h2409_0002, 1'b0, NO_EX));
    icache_busy  = 1'b0;
    icache_rdata = 32'h2408_0001;
    @(negedge clk);
    check("stream0_valid",   70'(fs_to_ds_valid), 70'(1));
    check("stream0_allowin", 70'(fs_allowin), 70'(1));
    cyc();
    idle_ps();
    icache_rdata = 32'h2409_0002;
    @(negedge clk);
    check("stream1_valid", 70'(fs_to_ds_valid), 70'(1));
    cyc();
    icache_busy = 1'b1;
    @(negedge clk);
    check("stream_empty", 70'(fs_to_ds_valid), 70'(0));
    check("stream_sb",    70'(sb.size()), 70'(0));
    cyc();

    // ---------------- decode stall ----------------
    offer(1'b1, 32'hBFC0_0008, 1'b0, NO_EX);
    sb.push_back(mk_ds(32'hBFC0_0008, 32'h3C1D_8000, 1'b0, NO_EX));
    ds_allowin = 1'b0;
    cyc();
    idle_ps();
    icache_busy  = 1'b0;
    icache_rdata = 32'h3C1D_8000;
    @(negedge clk);
    check("stall0_allowin", 70'(fs_allowin), 70'(0));
    for (int i = 1; i < 3; i++) begin
      cyc();
      icache_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("stall_buf_valid", 70'(dut.buf_valid), 70'(1));
      check("stall_allowin",   70'(fs_allowin), 70'(0));
      check("stall_valid",     70'(fs_to_ds_valid), 70'(1));
    end
    cyc();
    ds_allowin = 1'b1;
    @(negedge clk);
    check("stall_release_valid", 70'(fs_to_ds_valid), 70'(1));
    cyc();
    icache_busy = 1'b1;
    wait_drain("stall");

    // ---------------- ICache miss ----------------
    offer(1'b1, 32'hBFC0_000C, 1'b0, NO_EX);
    sb.push_back(mk_ds(32'hBFC0_000C, 32'h8C02_0000, 1'b0, NO_EX));
    cyc();
    idle_ps();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("miss_valid",   70'(fs_to_ds_valid), 70'(0));
      check("miss_allowin", 70'(fs_allowin), 70'(0));
      cyc();
    end
    icache_busy  = 1'b0;
    icache_rdata = 32'h8C02_0000;
    @(negedge clk);
    check("miss_done_valid", 70'(fs_to_ds_valid), 70'(1));
    cyc();
    icache_busy = 1'b1;
    wait_drain("miss");

    // ---------------- flush mid-miss ----------------
    offer(1'b1, 32'hBFC0_0010, 1'b0, NO_EX);
    cyc();
    idle_ps();
    flush = 1'b1;
    @(negedge clk);
    check("flush_valid",   70'(fs_to_ds_valid), 70'(0));
    check("flush_allowin", 70'(fs_allowin), 70'(1));
    cyc();
    flush = 1'b0;
    offer(1'b1, 32'hBFC0_0380, 1'b0, NO_EX);
    sb.push_back(mk_ds(32'hBFC0_0380, 32'h4080_6000, 1'b0, NO_EX));
    cyc();
    idle_ps();
    icache_busy  = 1'b0;
    icache_rdata = 32'h1111_1111;
    @(negedge clk);
    check("stale_dropped", 70'(fs_to_ds_valid), 70'(0));
    cyc();
    icache_rdata = 32'h4080_6000;
    @(negedge clk);
    check("post_flush_valid", 70'(fs_to_ds_valid), 70'(1));
    cyc();
    icache_busy = 1'b1;
    wait_drain("flush");

    // ---------------- exception slot ----------------
    offer(1'b0, 32'hBFC0_0002, 1'b1, EXC_ADEL);
    sb.push_back(mk_ds(32'hBFC0_0002, 32'h0, 1'b1, EXC_ADEL));
    cyc();
    idle_ps();
    icache_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("exc_valid", 70'(fs_to_ds_valid), 70'(1));
    cyc();
    wait_drain("exc");

    // ---------------- br_flush with simultaneous PS valid ----------------
    offer(1'b1, 32'hBFC0_0014, 1'b0, NO_EX);
    cyc();
    offer(1'b1, 32'hBFC0_0020, 1'b0, NO_EX);
    br_flush     = 1'b1;
    icache_busy  = 1'b0;
    icache_rdata = 32'h1234_5678;
    @(negedge clk);
    check("brf_valid",   70'(fs_to_ds_valid), 70'(0));
    check("brf_allowin", 70'(fs_allowin), 70'(1));
    cyc();
    br_flush    = 1'b0;
    icache_busy = 1'b1;
    idle_ps();
    @(negedge clk);
    check("brf_fs_valid",   70'(dut.fs_valid), 70'(0));
    check("brf_next_valid", 70'(fs_to_ds_valid), 70'(0));
    cyc();

    // Recovery after br_flush: a normal fetch goes straight through.
    offer(1'b1, 32'hBFC0_0040, 1'b0, NO_EX);
    sb.push_back(mk_ds(32'hBFC0_0040, 32'h0000_0021, 1'b0, NO_EX));
    cyc();
    idle_ps();
    icache_busy  = 1'b0;
    icache_rdata = 32'h0000_0021;
    cyc();
    icache_busy = 1'b1;
    wait_drain("recover");

    check("sb_empty", 70'(sb.size()), 70'(0));
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
